// File: rtl/arb_rr_if.sv
// Arbiter request/grant bundle: requester-side inputs and grant-side outputs.
interface arb_rr_if #(
   parameter int NUM_REQ = 4,
   parameter int TO_W    = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] en_mask;
   logic               mode;
   logic [TO_W-1:0]    timeout_val;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [IDW-1:0]     grant_id;
   logic               timeout_pulse;
   logic [15:0]        grant_cnt;

   // the arbiter side
   modport slave (
      input  req, done, en_mask, mode, timeout_val,
      output grant, grant_valid, grant_id, timeout_pulse, grant_cnt
   );

   // the requester side
   modport master (
      output req, done, en_mask, mode, timeout_val,
      input  grant, grant_valid, grant_id, timeout_pulse, grant_cnt
   );
endinterface

// File: rtl/arb_rr_core.sv
// Round-robin / fixed-priority arbiter with grant timeout and a one-cycle
// release gap. All outputs are registered, so reset clears them at once.
module arb_rr_core #(
   parameter int NUM_REQ = 4,
   parameter int TO_W    = 8
) (
   input  logic     ACLK,
   input  logic     ARESETN,
   arb_rr_if.slave  bus
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic               pulse_q, pulse_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [NUM_REQ-1:0] eligible;
   logic               win_found;
   logic [IDW-1:0]     win_id;
   int                 idx;
   logic               done_sel, req_sel, to_hit, rel;

   assign eligible = bus.req & bus.en_mask;
   assign done_sel = bus.done[id_q];
   assign req_sel  = bus.req[id_q];
   assign to_hit   = (bus.timeout_val != '0) && (to_q == bus.timeout_val - TO_W'(1));
   assign rel      = done_sel | ~req_sel | to_hit;

   // winner search: upward from ptr with wrap (RR) or from index 0 (fixed)
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = bus.mode ? i : (int'(ptr_q) + i) % NUM_REQ;
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
   end

   // next state and next register values
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      to_d    = to_q;
      pulse_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (win_found) begin
            state_d = GRANT;
            grant_d = NUM_REQ'(1) << win_id;
            id_d    = win_id;
            ptr_d   = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
            to_d    = '0;
            cnt_d   = cnt_q + 16'd1;
         end
         GRANT: if (rel) begin
            state_d = GAP;
            grant_d = '0;
            id_d    = '0;
            to_d    = '0;
            // a coincident done is a normal release, not a timeout
            pulse_d = to_hit & ~done_sel;
         end else begin
            to_d = to_q + TO_W'(1);
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         grant_q <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         to_q    <= '0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         to_q    <= to_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.grant         = grant_q;
   assign bus.grant_valid   = |grant_q;
   assign bus.grant_id      = id_q;
   assign bus.timeout_pulse = pulse_q;
   assign bus.grant_cnt     = cnt_q;
endmodule

// File: tb/tb_arb_rr_core.sv
// Directed bench for arb_rr_core: RR order, fixed priority, timeout,
// done/timeout collision, masking and asynchronous reset.
module tb_arb_rr_core;
   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   arb_rr_if #(.NUM_REQ(4), .TO_W(8)) bus ();

   arb_rr_core #(.NUM_REQ(4), .TO_W(8)) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // step until grant_valid, return number of edges taken
   task automatic wait_gv(input string tag, output int n);
      n = 0;
      while (!bus.grant_valid && n < 10) begin
         step();
         n++;
      end
      if (!bus.grant_valid) chk({tag, "_timeout"}, 32'(bus.grant_valid), 32'd1);
   endtask

   logic [3:0] rr_exp [5];
   int         n;

   initial begin
      rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4;
      rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
      bus.req = '0; bus.done = '0; bus.en_mask = '0; bus.mode = 1'b0;
      bus.timeout_val = '0;
      step(); step();
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_gv",    32'(bus.grant_valid), 32'h0);
      chk("rst_id",    32'(bus.grant_id), 32'h0);
      chk("rst_pulse", 32'(bus.timeout_pulse), 32'h0);
      chk("rst_cnt",   32'(bus.grant_cnt), 32'h0);
      ARESETN = 1'b1;
      step();

      // round-robin rotation, done one cycle into each grant
      bus.en_mask = 4'hF; bus.req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         wait_gv("rr", n);
         chk($sformatf("rr_grant%0d", i), 32'(bus.grant), 32'(rr_exp[i]));
         chk($sformatf("rr_lat%0d", i), 32'(n), (i == 0) ? 32'd1 : 32'd2);
         bus.done = bus.grant;
         step();
         bus.done = '0;
         chk($sformatf("rr_gap%0d", i), 32'(bus.grant), 32'h0);
      end
      chk("rr_cnt", 32'(bus.grant_cnt), 32'd5);
      bus.req = '0;
      step(); step();

      // fixed priority
      bus.mode = 1'b1; bus.req = 4'hC;
      wait_gv("fp", n);
      chk("fp_grant4", 32'(bus.grant), 32'h4);
      chk("fp_id2",    32'(bus.grant_id), 32'd2);
      bus.req = 4'hD;
      bus.en_mask = 4'h1;   // mask change must not revoke
      step();
      chk("fp_hold", 32'(bus.grant), 32'h4);
      bus.en_mask = 4'hF;
      bus.done = 4'hB;      // other done bits are ignored
      step();
      chk("fp_ign_done", 32'(bus.grant), 32'h4);
      bus.done = 4'h4;
      step();
      bus.done = '0;
      wait_gv("fp2", n);
      chk("fp_grant1", 32'(bus.grant), 32'h1);
      chk("fp_id0",    32'(bus.grant_id), 32'd0);
      bus.req = '0;
      step();
      chk("fp_reqdrop", 32'(bus.grant), 32'h0);
      step();
      bus.mode = 1'b0;

      // timeout after 3 grant cycles
      bus.timeout_val = 8'd3; bus.req = 4'h2;
      wait_gv("to", n);
      chk("to_c1", 32'(bus.grant), 32'h2);
      step();
      chk("to_c2", 32'(bus.grant), 32'h2);
      step();
      chk("to_c3", 32'(bus.grant), 32'h2);
      chk("to_c3_pulse", 32'(bus.timeout_pulse), 32'h0);
      step();
      chk("to_drop",  32'(bus.grant), 32'h0);
      chk("to_pulse", 32'(bus.timeout_pulse), 32'h1);
      step();
      chk("to_idle",  32'(bus.grant), 32'h0);
      chk("to_pulse_1cyc", 32'(bus.timeout_pulse), 32'h0);
      step();
      chk("to_regrant", 32'(bus.grant), 32'h2);

      // done in the 3rd grant cycle beats the timeout
      step(); step();
      chk("col_c3", 32'(bus.grant), 32'h2);
      bus.done = 4'h2;
      step();
      bus.done = '0;
      chk("col_drop",  32'(bus.grant), 32'h0);
      chk("col_pulse", 32'(bus.timeout_pulse), 32'h0);
      bus.req = '0; bus.timeout_val = '0;
      step(); step();

      // masked requester never wins
      bus.en_mask = 4'h7; bus.req = 4'h8;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("mask_none%0d", i), 32'(bus.grant_valid), 32'h0);
      end
      bus.en_mask = 4'hF;
      step();
      chk("mask_grant8", 32'(bus.grant), 32'h8);
      chk("mask_id3",    32'(bus.grant_id), 32'd3);
      chk("cnt_total",   32'(bus.grant_cnt), 32'd10);

      // asynchronous reset mid-grant
      #2 ARESETN = 1'b0;
      #1;
      chk("arst_grant", 32'(bus.grant), 32'h0);
      chk("arst_gv",    32'(bus.grant_valid), 32'h0);
      chk("arst_cnt",   32'(bus.grant_cnt), 32'h0);
      bus.req = 4'hF;
      step();
      chk("arst_hold", 32'(bus.grant), 32'h0);
      ARESETN = 1'b1;
      step();
      chk("arst_rr0", 32'(bus.grant), 32'h1);
      chk("arst_cnt1", 32'(bus.grant_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
